// File: rtl/ms11_mem.sv
`default_nettype none
// ============================================================================
// Module : ms11_mem
// Unibus semiconductor memory slave (DATI/DATIP/DATO/DATOB) with MSYN/SSYN.
// Rev    : 1.0
// ============================================================================
module ms11_mem #(
  parameter logic [17:0] BASE   = 18'o000000,
  parameter int          WORDS  = 'o20000,
  parameter int          DESKEW = 10,
  parameter int          ACCESS = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic [17:0] bus_a,
  input  logic        bus_c1,
  input  logic        bus_c0,
  input  logic [15:0] bus_d,
  input  logic        msyn,
  output logic        ssyn,
  output logic [15:0] bus_d_out,
  output logic        mem_sel,
  output logic        paused
);

  localparam int              c_IW        = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int              c_CNT_MAX   = (DESKEW > ACCESS) ? DESKEW : ACCESS;
  localparam int              c_CW        = $clog2(c_CNT_MAX + 1);
  localparam logic [c_CW-1:0] c_DESKEW_LD = c_CW'(DESKEW - 1);
  localparam logic [c_CW-1:0] c_ACCESS_LD = c_CW'(ACCESS - 1);
  localparam logic [18:0]     c_LIMIT     = 19'(BASE) + 19'(2 * WORDS);
  localparam logic [1:0]      c_DATI      = 2'b00;
  localparam logic [1:0]      c_DATIP     = 2'b01;
  localparam logic [1:0]      c_DATO      = 2'b10;
  localparam logic [1:0]      c_DATOB     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DESKEW  = 3'd1,
    S_ACCESS  = 3'd2,
    S_SSYN    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_CW-1:0]   r_cnt;
  logic [c_CW-1:0]   w_cnt_nxt;
  logic              r_msyn_d;
  logic [17:0]       r_addr;
  logic [1:0]        r_cycle;
  logic [15:0]       r_data;
  logic              r_ssyn;
  logic              w_ssyn_nxt;
  logic [15:0]       r_dout;
  logic [15:0]       w_dout_nxt;
  logic              r_sel;
  logic              w_sel_nxt;
  logic              r_paused;
  logic              w_paused_nxt;
  logic              w_capture;
  logic              w_access;
  logic              w_match;
  logic [c_IW-1:0]   w_index;
  logic [15:0]       r_rdata;
  logic [15:0]       r_mem [0:WORDS-1];

  // The I/O page is excluded regardless of where the window sits.
  assign w_match = (bus_a >= BASE) && (19'(bus_a) < c_LIMIT) && (bus_a[17:13] != 5'o37);
  assign w_index = c_IW'((r_addr - BASE) >> 1);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_ssyn_nxt   = r_ssyn;
    w_dout_nxt   = r_dout;
    w_sel_nxt    = r_sel;
    w_paused_nxt = r_paused;
    w_capture    = 1'b0;
    w_access     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (msyn && !r_msyn_d) begin
          w_state_nxt = S_DESKEW;
          w_cnt_nxt   = c_DESKEW_LD;
        end
      end
      S_DESKEW: begin
        if (!msyn) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_capture = 1'b1;
          if (w_match) begin
            w_sel_nxt   = 1'b1;
            w_state_nxt = S_ACCESS;
            w_cnt_nxt   = c_ACCESS_LD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - c_CW'(1);
        end
      end
      S_ACCESS: begin
        if (!msyn) begin
          w_sel_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == '0) begin
          w_access    = 1'b1;
          w_state_nxt = S_SSYN;
        end else begin
          w_cnt_nxt = r_cnt - c_CW'(1);
        end
      end
      S_SSYN: begin
        w_ssyn_nxt   = 1'b1;
        w_dout_nxt   = r_cycle[1] ? 16'h0000 : r_rdata;
        w_paused_nxt = (r_cycle == c_DATIP);
        w_state_nxt  = S_RELEASE;
      end
      S_RELEASE: begin
        if (!msyn) begin
          w_ssyn_nxt  = 1'b0;
          w_dout_nxt  = 16'h0000;
          w_sel_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (init) begin
      w_state_nxt  = S_IDLE;
      w_ssyn_nxt   = 1'b0;
      w_dout_nxt   = 16'h0000;
      w_sel_nxt    = 1'b0;
      w_paused_nxt = 1'b0;
      w_capture    = 1'b0;
      w_access     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_msyn_d <= 1'b0;
      r_addr   <= '0;
      r_cycle  <= c_DATI;
      r_data   <= '0;
      r_ssyn   <= 1'b0;
      r_dout   <= '0;
      r_sel    <= 1'b0;
      r_paused <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_msyn_d <= msyn;
      r_ssyn   <= w_ssyn_nxt;
      r_dout   <= w_dout_nxt;
      r_sel    <= w_sel_nxt;
      r_paused <= w_paused_nxt;
      if (w_capture) begin
        r_addr  <= bus_a;
        r_cycle <= {bus_c1, bus_c0};
        r_data  <= bus_d;
      end
    end
  end

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (w_access) begin
      unique case (r_cycle)
        c_DATO:  r_mem[w_index] <= r_data;
        c_DATOB: begin
          if (r_addr[0]) r_mem[w_index][15:8] <= r_data[15:8];
          else           r_mem[w_index][7:0]  <= r_data[7:0];
        end
        default: r_rdata <= r_mem[w_index];
      endcase
    end
  end

  assign ssyn      = r_ssyn;
  assign bus_d_out = r_dout;
  assign mem_sel   = r_sel;
  assign paused    = r_paused;

endmodule
`default_nettype wire
